trail_compositor: RTL and testbench

- Pipelined, parametrised successor to the two-bike pixel combiner.
- Reads packed colour-enum pixels from the frame buffer and overlays NUM_PLAYERS bike sprite pixels in fixed priority order.
- Counts per-player collision pixels across a frame and commits debounced, frame-latched collision flags on each frame boundary.
- Sits between the VGA scan counters and frame buffer on one side, and the palette lookup and game FSM on the other.

---
 rtl/trail_pkg.sv | 21 ++
 rtl/hit_counter.sv | 44 ++++
 rtl/trail_compositor.sv | 155 +++++++++++++++
 tb/tb_trail_compositor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/trail_pkg.sv
// Shared types, constants and helpers for the trail compositor.
package trail_pkg;

  localparam int unsigned PIX_W_C    = 4;
  localparam int unsigned MAX_WORD_W = 64;

  typedef logic [PIX_W_C-1:0] color_t;

  localparam color_t TRANSPARENT_C = 4'hF;
  localparam color_t BG_EMPTY_C    = 4'h8;

  // Pull pixel lane 'lane' out of a frame-buffer word; lanes sit on 8-bit strides.
  function automatic color_t lane_extract(input logic [MAX_WORD_W-1:0] word,
                                          input int unsigned lane);
    if ((8 * lane) + PIX_W_C > MAX_WORD_W) begin
      return BG_EMPTY_C;
    end
    return word[8*lane +: PIX_W_C];
  endfunction

endpackage

// File: rtl/hit_counter.sv
// Saturating per-frame hit counter with synchronous clear and threshold compare.
// A clear and an increment in the same cycle restart the count at 1 so the
// coincident hit lands in the new frame.
module hit_counter #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned THRESH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic above_c
);

  localparam logic [CNT_W-1:0] MAX_C    = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // Next count: clear wins but keeps a coincident hit, otherwise saturate.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = inc ? ONE_C : '0;
    end else if (inc && (count != MAX_C)) begin
      count_next = count + ONE_C;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Threshold compare on the pre-update count, used by the frame commit.
  assign above_c = (count >= THRESH_C);

endmodule

// File: rtl/trail_compositor.sv
// Three-stage pixel compositor: frame-buffer address, RAM wait, then sprite
// overlay plus per-player collision counting with frame-latched flags.
module trail_compositor
  import trail_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned PIX_W        = 4,
  parameter int unsigned PIX_PER_WORD = 2,
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned H_RES        = 640,
  parameter int unsigned ADDR_W       = 19,
  parameter logic [PIX_W-1:0] TRANSPARENT = PIX_W'(TRANSPARENT_C),
  parameter int unsigned HIT_THRESH   = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_start,
  input  logic                         pix_valid,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  input  logic [NUM_PLAYERS*PIX_W-1:0] sprite_pix,
  input  logic [NUM_PLAYERS*PIX_W-1:0] trail_color,
  output logic [ADDR_W-1:0]            fb_rd_addr,
  input  logic [WORD_W-1:0]            fb_rd_data,
  output logic [PIX_W-1:0]             color_enum,
  output logic                         color_valid,
  output logic [NUM_PLAYERS-1:0]       collided,
  output logic                         collide_strobe
);

  localparam int unsigned SPR_W      = NUM_PLAYERS * PIX_W;
  localparam int unsigned LANE_W     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int unsigned LINE_WORDS = H_RES / PIX_PER_WORD;

  // S0 / S1 pipeline state
  logic              v0, v1;
  logic [LANE_W-1:0] lane0, lane1;
  logic [SPR_W-1:0]  spr0, spr1;

  // Scan-position decode
  logic [31:0]       addr_full_c;
  logic [LANE_W-1:0] lane_c;

  // S2 combinational results
  logic [PIX_W-1:0]       bg_c;
  logic [PIX_W-1:0]       pix_c;
  logic [NUM_PLAYERS-1:0] opaque_c;
  logic [NUM_PLAYERS-1:0] event_c;
  logic [NUM_PLAYERS-1:0] above_c;
  logic                   trail_hit_c;

  // Word address and lane of the current scan position.
  always_comb begin
    addr_full_c = (32'(DrawX) / PIX_PER_WORD) + (32'(DrawY) * LINE_WORDS);
    lane_c      = LANE_W'(32'(DrawX) % PIX_PER_WORD);
  end

  // S0: issue the frame-buffer read and capture lane/sprites alongside it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v0         <= 1'b0;
      fb_rd_addr <= '0;
      lane0      <= '0;
      spr0       <= '0;
    end else begin
      v0 <= pix_valid;
      if (pix_valid) begin
        fb_rd_addr <= ADDR_W'(addr_full_c);
        lane0      <= lane_c;
        spr0       <= sprite_pix;
      end
    end
  end

  // S1: hold lane/sprites for the RAM read latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v1    <= 1'b0;
      lane1 <= '0;
      spr1  <= '0;
    end else begin
      v1    <= v0;
      lane1 <= lane0;
      spr1  <= spr0;
    end
  end

  // S2 combinational: background lane, priority overlay, collision events.
  always_comb begin
    bg_c        = PIX_W'(lane_extract(MAX_WORD_W'(fb_rd_data), 32'(lane1)));
    pix_c       = bg_c;
    opaque_c    = '0;
    event_c     = '0;
    trail_hit_c = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      opaque_c[i] = (spr1[i*PIX_W +: PIX_W] != TRANSPARENT);
      if (bg_c == trail_color[i*PIX_W +: PIX_W]) begin
        trail_hit_c = 1'b1;
      end
    end
    // Walk from highest index down so the lowest opaque player wins.
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (opaque_c[i]) begin
        pix_c = spr1[i*PIX_W +: PIX_W];
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      event_c[i] = v1 && opaque_c[i] &&
                   (trail_hit_c ||
                    ((opaque_c & ~(NUM_PLAYERS'(1) << i)) != '0));
    end
  end

  // S2 register: composited pixel, held when no pixel is in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      color_valid <= 1'b0;
      color_enum  <= '0;
    end else begin
      color_valid <= v1;
      if (v1) begin
        color_enum <= pix_c;
      end
    end
  end

  // One saturating hit counter per player, cleared at each frame boundary.
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_hit
    hit_counter #(
      .CNT_W  (CNT_W),
      .THRESH (HIT_THRESH)
    ) u_hit_counter (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .clear   (frame_start),
      .inc     (event_c[g]),
      .above_c (above_c[g])
    );
  end

  // Frame commit: latch thresholded counts and pulse the strobe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      collided       <= '0;
      collide_strobe <= 1'b0;
    end else begin
      collide_strobe <= frame_start;
      if (frame_start) begin
        collided <= above_c;
      end
    end
  end

endmodule

// File: tb/tb_trail_compositor.sv
// Directed bench for trail_compositor with a one-cycle-latency RAM model.
module tb_trail_compositor;

  logic        Clk;
  logic        Reset_n;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [7:0]  sprite_pix;
  logic [7:0]  trail_color;
  logic [18:0] fb_rd_addr;
  logic [15:0] fb_rd_data;
  logic [3:0]  color_enum;
  logic        color_valid;
  logic [1:0]  collided;
  logic        collide_strobe;

  logic [15:0] ram [0:524287];

  int n_vec;
  int n_err;

  trail_compositor dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .sprite_pix     (sprite_pix),
    .trail_color    (trail_color),
    .fb_rd_addr     (fb_rd_addr),
    .fb_rd_data     (fb_rd_data),
    .color_enum     (color_enum),
    .color_valid    (color_valid),
    .collided       (collided),
    .collide_strobe (collide_strobe)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read frame buffer: data one cycle after address.
  always @(posedge Clk) fb_rd_data <= ram[fb_rd_addr];

  // Apply one scan position for one cycle, returning on the next falling edge.
  task automatic drive(input logic v, input logic [9:0] x, input logic [9:0] y,
                       input logic [7:0] spr);
    pix_valid  = v;
    DrawX      = x;
    DrawY      = y;
    sprite_pix = spr;
    @(negedge Clk);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    n_vec++; if (fb_rd_addr !== 19'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", fb_rd_addr); end
    n_vec++; if (color_enum !== 4'h0) begin n_err++; $display("FAIL reset_color: got %h want 0", color_enum); end
    n_vec++; if (color_valid !== 1'b0) begin n_err++; $display("FAIL reset_cv: got %b want 0", color_valid); end
    n_vec++; if (collided !== 2'b00) begin n_err++; $display("FAIL reset_collided: got %b want 00", collided); end
    n_vec++; if (collide_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b want 0", collide_strobe); end
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_latency();
    drive(1'b1, 10'd7, 10'd2, 8'hFF);
    n_vec++; if (fb_rd_addr !== 19'd643) begin n_err++; $display("FAIL lat_addr: got %0d want 643", fb_rd_addr); end
    n_vec++; if (color_valid !== 1'b0) begin n_err++; $display("FAIL lat_cv1: got %b want 0", color_valid); end
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    n_vec++; if (color_valid !== 1'b0) begin n_err++; $display("FAIL lat_cv2: got %b want 0", color_valid); end
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    n_vec++; if (color_valid !== 1'b1) begin n_err++; $display("FAIL lat_cv3: got %b want 1", color_valid); end
    n_vec++; if (color_enum !== 4'hE) begin n_err++; $display("FAIL lat_color: got %h want e", color_enum); end
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    n_vec++; if (color_valid !== 1'b0) begin n_err++; $display("FAIL lat_cv4: got %b want 0", color_valid); end
  endtask

  task automatic test_gap();
    drive(1'b1, 10'd20, 10'd0, 8'hFF);
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    drive(1'b1, 10'd22, 10'd0, 8'hFF);
    n_vec++; if (color_valid !== 1'b1) begin n_err++; $display("FAIL gap_cv_a: got %b want 1", color_valid); end
    n_vec++; if (color_enum !== 4'h8) begin n_err++; $display("FAIL gap_color_a: got %h want 8", color_enum); end
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    n_vec++; if (color_valid !== 1'b0) begin n_err++; $display("FAIL gap_cv_b: got %b want 0", color_valid); end
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    n_vec++; if (color_valid !== 1'b1) begin n_err++; $display("FAIL gap_cv_c: got %b want 1", color_valid); end
    n_vec++; if (color_enum !== 4'h3) begin n_err++; $display("FAIL gap_color_c: got %h want 3", color_enum); end
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
  endtask

  task automatic test_priority();
    drive(1'b1, 10'd20, 10'd0, 8'h46);
    drive(1'b1, 10'd21, 10'd0, 8'h4F);
    drive(1'b1, 10'd20, 10'd0, 8'hFF);
    n_vec++; if (color_enum !== 4'h6) begin n_err++; $display("FAIL prio_p0: got %h want 6", color_enum); end
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    n_vec++; if (color_enum !== 4'h4) begin n_err++; $display("FAIL prio_p1: got %h want 4", color_enum); end
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    n_vec++; if (color_enum !== 4'h8) begin n_err++; $display("FAIL prio_bg: got %h want 8", color_enum); end
    n_vec++; if (color_valid !== 1'b1) begin n_err++; $display("FAIL prio_cv: got %b want 1", color_valid); end
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    // one head-on pixel each so far: below threshold
    pulse_frame();
    n_vec++; if (collide_strobe !== 1'b1) begin n_err++; $display("FAIL prio_strobe: got %b want 1", collide_strobe); end
    n_vec++; if (collided !== 2'b00) begin n_err++; $display("FAIL prio_collided: got %b want 00", collided); end
    @(negedge Clk);
    n_vec++; if (collide_strobe !== 1'b0) begin n_err++; $display("FAIL prio_strobe_drop: got %b want 0", collide_strobe); end
  endtask

  task automatic test_trail_thresh();
    repeat (3) drive(1'b1, 10'd60, 10'd0, 8'hF2);
    repeat (3) drive(1'b0, 10'd0, 10'd0, 8'hFF);
    pulse_frame();
    n_vec++; if (collide_strobe !== 1'b1) begin n_err++; $display("FAIL trail3_strobe: got %b want 1", collide_strobe); end
    n_vec++; if (collided !== 2'b00) begin n_err++; $display("FAIL trail3_collided: got %b want 00", collided); end
    repeat (4) drive(1'b1, 10'd60, 10'd0, 8'hF2);
    n_vec++; if (collided !== 2'b00) begin n_err++; $display("FAIL trail_hold: got %b want 00", collided); end
    repeat (3) drive(1'b0, 10'd0, 10'd0, 8'hFF);
    pulse_frame();
    n_vec++; if (collide_strobe !== 1'b1) begin n_err++; $display("FAIL trail4_strobe: got %b want 1", collide_strobe); end
    n_vec++; if (collided !== 2'b01) begin n_err++; $display("FAIL trail4_collided: got %b want 01", collided); end
  endtask

  task automatic test_head_on();
    repeat (4) drive(1'b1, 10'd20, 10'd0, 8'h32);
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    n_vec++; if (color_enum !== 4'h2) begin n_err++; $display("FAIL headon_color: got %h want 2", color_enum); end
    repeat (2) drive(1'b0, 10'd0, 10'd0, 8'hFF);
    pulse_frame();
    n_vec++; if (collided !== 2'b11) begin n_err++; $display("FAIL headon_collided: got %b want 11", collided); end
  endtask

  task automatic test_boundary();
    // fourth hit reaches S2 on the same edge that samples frame_start
    repeat (4) drive(1'b1, 10'd60, 10'd0, 8'hF2);
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    frame_start = 1'b1;
    drive(1'b0, 10'd0, 10'd0, 8'hFF);
    frame_start = 1'b0;
    n_vec++; if (collide_strobe !== 1'b1) begin n_err++; $display("FAIL bound_strobe: got %b want 1", collide_strobe); end
    n_vec++; if (collided !== 2'b00) begin n_err++; $display("FAIL bound_commit: got %b want 00", collided); end
    repeat (3) drive(1'b1, 10'd60, 10'd0, 8'hF2);
    repeat (3) drive(1'b0, 10'd0, 10'd0, 8'hFF);
    pulse_frame();
    n_vec++; if (collided !== 2'b01) begin n_err++; $display("FAIL bound_carry: got %b want 01", collided); end
  endtask

  task automatic test_reset_mid();
    repeat (10) drive(1'b1, 10'd60, 10'd0, 8'hF2);
    repeat (3) drive(1'b0, 10'd0, 10'd0, 8'hFF);
    Reset_n = 1'b0;
    #1;
    n_vec++; if (collided !== 2'b00) begin n_err++; $display("FAIL rmid_collided: got %b want 00", collided); end
    n_vec++; if (fb_rd_addr !== 19'd0) begin n_err++; $display("FAIL rmid_addr: got %0d want 0", fb_rd_addr); end
    n_vec++; if (color_enum !== 4'h0) begin n_err++; $display("FAIL rmid_color: got %h want 0", color_enum); end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    pulse_frame();
    n_vec++; if (collide_strobe !== 1'b1) begin n_err++; $display("FAIL rmid_strobe: got %b want 1", collide_strobe); end
    n_vec++; if (collided !== 2'b00) begin n_err++; $display("FAIL rmid_commit: got %b want 00", collided); end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    Clk         = 1'b0;
    Reset_n     = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
    sprite_pix  = 8'hFF;
    trail_color = 8'h46;
    for (int a = 0; a < 524288; a++) ram[a] = 16'h8888;
    ram[643] = 16'h0E06;
    ram[10]  = 16'h0808;
    ram[11]  = 16'h0803;
    ram[30]  = 16'h0404;

    test_reset();
    test_latency();
    test_gap();
    test_priority();
    test_trail_thresh();
    test_head_on();
    test_boundary();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
